ama_riscv_store_shift_mask: RTL and testbench

//  Write-path counterpart of the DMEM load path: takes a store request (byte address, width, data)
//  and produces DMEM write beats: word address, lane-aligned data, per-byte write enables.

---
 rtl/ama_riscv_store_shift_mask.sv | 154 +++++++++++++++
 tb/tb_ama_riscv_store_shift_mask.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_store_shift_mask.sv
// Store write path: turns a byte-addressed store request into lane-aligned
// DMEM write beats, splitting or rejecting stores that cross a word boundary.
module ama_riscv_store_shift_mask #(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_width,
    input  logic [31:0]       req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    output logic              misaligned,
    output logic              busy
);

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        hi_we_q, hi_we_d;
    logic [31:0]       hi_wdata_q, hi_wdata_d;
    logic              split_q, split_d;
    logic              misal_q, misal_d;

    logic [1:0]  off;
    logic [3:0]  base;
    logic [31:0] dmask;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic        misal;
    logic        rsvd;
    logic        last;

    assign off = req_addr[1:0];

    always_comb begin
        base  = 4'b0000;
        dmask = 32'h0;
        case (req_width)
            W_BYTE: begin
                base  = 4'b0001;
                dmask = 32'h0000_00ff;
            end
            W_HALF: begin
                base  = 4'b0011;
                dmask = 32'h0000_ffff;
            end
            W_WORD: begin
                base  = 4'b1111;
                dmask = 32'hffff_ffff;
            end
            default: begin
                base  = 4'b0000;
                dmask = 32'h0;
            end
        endcase
    end

    assign mask8  = {4'b0000, base} << off;
    assign data64 = {32'h0, req_data & dmask} << {off, 3'b000};
    assign misal  = ((req_width == W_HALF) && (off == 2'd3)) ||
                    ((req_width == W_WORD) && (off != 2'd0));
    assign rsvd   = (req_width == 2'b11);

    // Current beat is the final one of its store
    assign last      = (state_q == HI) || ((state_q == LO) && !split_q);
    assign mem_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE) || (mem_ready && last);

    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign misaligned = misal_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        hi_we_d    = hi_we_q;
        hi_wdata_d = hi_wdata_q;
        split_d    = split_q;
        misal_d    = 1'b0;
        if ((state_q == LO) && split_q && mem_ready) begin
            state_d = HI;
            addr_d  = addr_q + ADDR_W'(1);
            we_d    = hi_we_q;
            wdata_d = hi_wdata_q;
            split_d = 1'b0;
        end else if (req_ready) begin
            state_d = IDLE;
            we_d    = 4'b0000;
            wdata_d = 32'h0;
            split_d = 1'b0;
            if (req_valid && !rsvd) begin
                if (misal && !SPLIT_MISALIGNED) begin
                    misal_d = 1'b1;
                end else begin
                    state_d    = LO;
                    addr_d     = req_addr[ADDR_W+1:2];
                    we_d       = mask8[3:0];
                    wdata_d    = data64[31:0];
                    hi_we_d    = mask8[7:4];
                    hi_wdata_d = data64[63:32];
                    split_d    = misal;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            hi_we_q    <= 4'b0000;
            hi_wdata_q <= 32'h0;
            split_q    <= 1'b0;
            misal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            hi_we_q    <= hi_we_d;
            hi_wdata_q <= hi_wdata_d;
            split_q    <= split_d;
            misal_q    <= misal_d;
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

endmodule

// File: tb/tb_ama_riscv_store_shift_mask.sv
// Bench for the store shift/mask unit: directed and random stores against a
// byte-by-byte reference model, with a second instance for reject mode.
module tb_ama_riscv_store_shift_mask;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_width = '0;
    logic [31:0]   req_data = '0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic          misaligned;
    logic          busy;

    logic          r0_valid = 1'b0;
    logic          r0_ready;
    logic [31:0]   r0_addr = '0;
    logic [1:0]    r0_width = '0;
    logic [31:0]   r0_data = '0;
    logic          m0_valid;
    logic          m0_ready = 1'b1;
    logic [AW-1:0] m0_addr;
    logic [3:0]    m0_we;
    logic [31:0]   m0_wdata;
    logic          m0_misal;
    logic          m0_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ama_riscv_store_shift_mask #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_width(req_width), .req_data(req_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .misaligned(misaligned), .busy(busy)
    );

    ama_riscv_store_shift_mask #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(AW)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(r0_valid), .req_ready(r0_ready),
        .req_addr(r0_addr), .req_width(r0_width), .req_data(r0_data),
        .mem_valid(m0_valid), .mem_ready(m0_ready),
        .mem_addr(m0_addr), .mem_we(m0_we), .mem_wdata(m0_wdata),
        .misaligned(m0_misal), .busy(m0_busy)
    );

    typedef struct {
        int                   n;
        logic [1:0][AW-1:0]   addr;
        logic [1:0][3:0]      we;
        logic [1:0][31:0]     wd;
    } exp_t;

    // Place each stored byte at its own byte address; bytes past the first
    // word land in the second beat.
    function automatic exp_t model(logic [31:0] a, logic [1:0] w,
                                   logic [31:0] d);
        exp_t        e;
        int          nb;
        int          slot;
        logic [31:0] b;
        e.n    = 0;
        e.addr = '0;
        e.we   = '0;
        e.wd   = '0;
        nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
        for (int i = 0; i < nb; i++) begin
            b    = a + 32'(i);
            slot = ((b >> 2) != (a >> 2)) ? 1 : 0;
            e.we[slot][b[1:0]] = 1'b1;
            e.wd[slot][8*b[1:0] +: 8] = d[8*i +: 8];
        end
        e.addr[0] = a[AW+1:2];
        e.addr[1] = e.addr[0] + AW'(1);
        if (nb == 0) e.n = 0;
        else if (e.we[1] != 4'b0000) e.n = 2;
        else e.n = 1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input exp_t e, input int k);
        chk({tag, "_valid"}, 64'(mem_valid), 64'(1'b1));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(e.addr[k]));
        chk({tag, "_we"}, 64'(mem_we), 64'(e.we[k]));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e.wd[k]));
        chk({tag, "_misal"}, 64'(misaligned), 64'(1'b0));
    endtask

    // One store with beat 0 stalled for 'stall' cycles; ends with the DUT idle.
    task automatic run_store(input string tag, input logic [31:0] a,
                             input logic [1:0] w, input logic [31:0] d,
                             input int stall);
        exp_t e;
        e = model(a, w, d);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_width = w;
        req_data  = d;
        mem_ready = 1'b1;
        #1;
        chk({tag, "_ready_idle"}, 64'(req_ready), 64'(1'b1));
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_width = 2'($urandom);
        req_data  = $urandom;
        if (e.n == 0) begin
            chk({tag, "_rsvd_valid"}, 64'(mem_valid), 64'(1'b0));
            chk({tag, "_rsvd_misal"}, 64'(misaligned), 64'(1'b0));
            return;
        end
        for (int k = 0; k < e.n; k++) begin
            if (k == 0) begin
                for (int s = 0; s < stall; s++) begin
                    mem_ready = 1'b0;
                    #1;
                    chk_beat({tag, "_stall"}, e, 0);
                    chk({tag, "_stall_ready"}, 64'(req_ready), 64'(1'b0));
                    @(negedge clk);
                end
            end
            mem_ready = 1'b1;
            #1;
            chk_beat({tag, "_beat"}, e, k);
            chk({tag, "_busy"}, 64'(busy), 64'(1'b1));
            chk({tag, "_ready_last"}, 64'(req_ready),
                64'((k == e.n - 1) ? 1'b1 : 1'b0));
            @(negedge clk);
        end
        chk({tag, "_done_valid"}, 64'(mem_valid), 64'(1'b0));
        chk({tag, "_done_busy"}, 64'(busy), 64'(1'b0));
    endtask

    initial begin
        exp_t q[4];
        exp_t e;
        logic [31:0] a;

        #12;
        chk("rst_valid", 64'(mem_valid), 64'(1'b0));
        chk("rst_we", 64'(mem_we), 64'(4'b0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_misal", 64'(misaligned), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        @(negedge clk);
        rst = 1'b1;

        run_store("sb_1003", 32'h0000_1003, 2'd0, 32'hAABB_CCDD, 0);
        run_store("sh_2002", 32'h0000_2002, 2'd1, 32'hFFFF_1234, 0);
        run_store("sw_0001", 32'h0000_0001, 2'd2, 32'h1122_3344, 0);
        run_store("sh_wrap", {16'h0, 14'h3FFF, 2'd3}, 2'd1, 32'h0000_BEEF, 0);
        run_store("sw_wrapw", {16'h0, 14'h3FFF, 2'd2}, 2'd2, 32'hCAFE_F00D, 1);
        run_store("sw_stall", 32'h0000_0040, 2'd2, 32'h5566_7788, 3);
        run_store("rsvd", 32'h0000_0100, 2'd3, 32'h1234_5678, 0);

        // Back-to-back aligned words, one beat per cycle
        @(negedge clk);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a    = {$urandom} & 32'hFFFF_FFFC;
            q[i] = model(a, 2'd2, $urandom);
        end
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) chk_beat("b2b", q[i-1], 0);
            if (i < 4) begin
                req_valid = 1'b1;
                req_addr  = {q[i].addr[0], 2'b00};
                req_width = 2'd2;
                req_data  = q[i].wd[0];
                #1;
                chk("b2b_ready", 64'(req_ready), 64'(1'b1));
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_end", 64'(mem_valid), 64'(1'b0));

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if (i % 4 == 0) a = {a[31:16], 14'h3FFF, a[1:0]};
            run_store("rnd", a, 2'($urandom), $urandom, int'($urandom_range(0, 2)));
        end

        // Reject mode: misaligned pulse, no beat
        @(negedge clk);
        r0_valid = 1'b1;
        r0_addr  = 32'h0000_2003;
        r0_width = 2'd1;
        r0_data  = 32'h0000_ABCD;
        #1;
        chk("rej_ready", 64'(r0_ready), 64'(1'b1));
        @(negedge clk);
        r0_valid = 1'b0;
        chk("rej_pulse", 64'(m0_misal), 64'(1'b1));
        chk("rej_valid", 64'(m0_valid), 64'(1'b0));
        @(negedge clk);
        chk("rej_pulse_end", 64'(m0_misal), 64'(1'b0));
        chk("rej_valid2", 64'(m0_valid), 64'(1'b0));
        e = model(32'h0000_2002, 2'd1, 32'h0000_ABCD);
        r0_valid = 1'b1;
        r0_addr  = 32'h0000_2002;
        @(negedge clk);
        r0_valid = 1'b0;
        chk("rej_al_valid", 64'(m0_valid), 64'(1'b1));
        chk("rej_al_we", 64'(m0_we), 64'(e.we[0]));
        chk("rej_al_wdata", 64'(m0_wdata), 64'(e.wd[0]));
        chk("rej_al_misal", 64'(m0_misal), 64'(1'b0));
        @(negedge clk);
        chk("rej_al_done", 64'(m0_valid), 64'(1'b0));

        // Reset asserted while the high beat of a split store is waiting
        e = model(32'h0000_0013, 2'd2, 32'hDEAD_BEEF);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0013;
        req_width = 2'd2;
        req_data  = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk_beat("rsthi_lo", e, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        chk_beat("rsthi_hi", e, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rsthi_valid", 64'(mem_valid), 64'(1'b0));
        chk("rsthi_busy", 64'(busy), 64'(1'b0));
        chk("rsthi_we", 64'(mem_we), 64'(4'b0));
        chk("rsthi_wdata", 64'(mem_wdata), 64'(0));
        chk("rsthi_addr", 64'(mem_addr), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rsthi_after", 64'(mem_valid), 64'(1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
